// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIFO write-port arbiter.
// The helper is written for up to MAX_REQ requesters so other schedulers can reuse it.
package fifo_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input int                 ptr,
                                         input int                 n);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            cand = (ptr + k) % n;
            if ((k < n) && !res.found && req[IDX_W'(cand)]) begin
                res.found = 1'b1;
                res.idx   = IDX_W'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest-distance requester starting from ptr.
// Purely combinational so the caller decides when the winner is registered.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    grant_idx
);

    rr_pick_t pick;
    logic     unused_idx_hi;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req), int'(ptr), NUM_REQ);
        found     = pick.found;
        grant_idx = pick.idx[ID_W-1:0];
    end

    // Upper index bits are structurally zero when NUM_REQ < MAX_REQ.
    assign unused_idx_hi = ^pick.idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one syncFifo write port between NUM_REQ producers with round-robin
// arbitration, holding the grant until a last-flagged word or MAX_BURST words.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e             state, state_nxt;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       burst_cnt;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;

    logic                   own_valid;
    logic                   own_last;
    logic [DATA_WIDTH-1:0]  own_data;
    logic                   xfer;
    logic                   burst_done;
    logic                   grant_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .found     (pick_found),
        .grant_idx (pick_idx)
    );

    // Owner's request lines, selected by the registered grant.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // fifo_full gates every write; the FIFO's own overflow guard is never exercised.
    always_comb begin
        busy         = (state == GRANT);
        xfer         = busy && own_valid && !fifo_full;
        req_ready    = '0;
        if (busy && !fifo_full) begin
            req_ready = NUM_REQ'(1) << grant_id;
        end
        fifo_wr      = xfer;
        fifo_data_in = xfer ? own_data : '0;
        burst_done   = (burst_cnt == CNT_W'(MAX_BURST - 1));
        grant_end    = xfer && (own_last || burst_done);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_found) state_nxt = GRANT;
            GRANT:   if (grant_end)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner is latched in IDLE; no word moves until the following cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            grant_id <= '0;
        end else if ((state == IDLE) && pick_found) begin
            grant_id <= pick_idx;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr <= '0;
        end else if (grant_end) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            burst_cnt <= '0;
        end else if (grant_end) begin
            burst_cnt <= '0;
        end else if (xfer) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer and 16-deep FIFO models drive the
// DUT, and every observation is compared against hand-derived values.
module tb_fifo_wr_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             nrst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             fifo_wr;
    logic [DW-1:0]    fifo_data_in;
    logic             fifo_full;
    logic [1:0]       grant_id;
    logic             busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr      (fifo_wr),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit          en[NR];
    bit          hold[NR];
    int          cnt[NR];
    int          nwords[NR];
    int          last_at[NR];
    logic [7:0]  base[NR];
    bit          auto_rd;
    logic [7:0]  fq[$];
    logic [1:0]  log_id[$];
    logic [7:0]  log_d[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]          = en[i] && !hold[i] && (cnt[i] < nwords[i]);
            req_last[i]           = (cnt[i] == last_at[i]);
            req_data[i*DW +: DW]  = base[i] + 8'(cnt[i]);
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // Samples the DUT just before the edge, then applies FIFO and producer updates.
    task automatic step();
        logic          s_wr;
        logic [7:0]    s_d;
        logic [NR-1:0] s_rdy;
        logic [NR-1:0] s_v;
        logic [1:0]    s_g;
        s_wr  = fifo_wr;
        s_d   = fifo_data_in;
        s_rdy = req_ready;
        s_v   = req_valid;
        s_g   = grant_id;
        @(posedge clk);
        if (auto_rd && fq.size() > 0) void'(fq.pop_front());
        if (s_wr) begin
            fq.push_back(s_d);
            log_id.push_back(s_g);
            log_d.push_back(s_d);
        end
        for (int i = 0; i < NR; i++) begin
            if (s_v[i] && s_rdy[i]) cnt[i]++;
        end
        #1;
        fifo_full = (fq.size() >= DEPTH);
        settle();
    endtask

    task automatic clear_prod();
        for (int i = 0; i < NR; i++) begin
            en[i] = 1'b0; hold[i] = 1'b0; cnt[i] = 0;
            nwords[i] = 0; last_at[i] = 99; base[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        clear_prod();
        auto_rd   = 1'b0;
        fq.delete();
        fifo_full = 1'b0;
        nrst      = 1'b0;
        settle();
        step();
        nrst = 1'b1;
        settle();
        log_id.delete();
        log_d.delete();
    endtask

    task automatic prefill(input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'hEE);
        fifo_full = (fq.size() >= DEPTH);
    endtask

    // Producers must hold data/last while valid and not accepted.
    logic [NR-1:0]    p_v, p_r, p_l;
    logic [NR*DW-1:0] p_d;
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (nrst && p_v[i] && !p_r[i] && req_valid[i]) begin
                assert (req_data[i*DW +: DW] == p_d[i*DW +: DW] && req_last[i] == p_l[i])
                    else $error("producer %0d changed data while stalled", i);
            end
        end
        p_v <= req_valid;
        p_r <= req_ready;
        p_l <= req_last;
        p_d <= req_data;
    end

    initial begin
        clear_prod();
        auto_rd   = 1'b0;
        fifo_full = 1'b0;
        nrst      = 1'b0;
        settle();

        chk("rst_busy", busy, 0);
        chk("rst_wr", fifo_wr, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", fifo_data_in, 0);
        chk("rst_gid", grant_id, 0);

        // single requester packet of three words
        do_reset();
        en[0] = 1; nwords[0] = 3; last_at[0] = 2; base[0] = 8'hA1;
        settle();
        chk("t1_arb_busy", busy, 0);
        chk("t1_arb_wr", fifo_wr, 0);
        step();
        chk("t1_busy", busy, 1);
        chk("t1_gid", grant_id, 0);
        for (int k = 0; k < 3; k++) begin
            chk("t1_wr", fifo_wr, 1);
            chk("t1_data", fifo_data_in, 32'hA1 + k);
            chk("t1_ready", req_ready, 4'b0001);
            step();
        end
        chk("t1_end_busy", busy, 0);
        chk("t1_end_wr", fifo_wr, 0);
        chk("t1_fifo_n", fq.size(), 3);
        for (int k = 0; k < 3; k++) chk("t1_fifo_rd", fq[k], 32'hA1 + k);

        // four requesters, bursts capped at four words
        do_reset();
        for (int i = 0; i < NR; i++) begin
            en[i] = 1; nwords[i] = 4; base[i] = 8'(8'h10 * (i + 1));
        end
        nwords[0] = 8;
        auto_rd   = 1'b1;
        settle();
        for (int c = 0; c < 25; c++) begin
            chk("t2_wr", fifo_wr, ((c % 5) != 0) ? 1 : 0);
            if ((c % 5) != 0) chk("t2_gid", grant_id, (c / 5) % 4);
            step();
        end
        chk("t2_idle", busy, 0);
        chk("t2_nlog", log_d.size(), 20);
        for (int j = 0; j < 20 && j < log_d.size(); j++) begin
            chk("t2_log_id", log_id[j], (j / 4) % 4);
            chk("t2_log_d", log_d[j], 32'(base[(j / 4) % 4]) + ((j >= 16) ? 4 : 0) + (j % 4));
        end

        // FIFO fills mid-burst; burst count survives the stall
        do_reset();
        prefill(15);
        en[2] = 1; nwords[2] = 4; base[2] = 8'hC0;
        settle();
        chk("t3_arb_wr", fifo_wr, 0);
        step();
        chk("t3_gid", grant_id, 2);
        chk("t3_ready", req_ready, 4'b0100);
        chk("t3_wr0", fifo_wr, 1);
        chk("t3_d0", fifo_data_in, 32'hC0);
        step();
        chk("t3_full", fifo_full, 1);
        for (int k = 0; k < 3; k++) begin
            chk("t3_stall_ready", req_ready, 0);
            chk("t3_stall_wr", fifo_wr, 0);
            chk("t3_stall_busy", busy, 1);
            if (k == 2) auto_rd = 1'b1;
            step();
        end
        for (int k = 1; k < 4; k++) begin
            chk("t3_ready_r", req_ready, 4'b0100);
            chk("t3_wr_r", fifo_wr, 1);
            chk("t3_d_r", fifo_data_in, 32'hC0 + k);
            step();
        end
        chk("t3_end_busy", busy, 0);
        chk("t3_nlog", log_d.size(), 4);

        // owner stalls its packet; a waiting requester stays locked out
        do_reset();
        en[1] = 1; nwords[1] = 3; last_at[1] = 2; base[1] = 8'h50;
        en[3] = 1; nwords[3] = 1; last_at[3] = 0; base[3] = 8'h70;
        settle();
        step();
        chk("t4_gid", grant_id, 1);
        chk("t4_d0", fifo_data_in, 32'h50);
        step();
        hold[1] = 1;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("t4_hold_wr", fifo_wr, 0);
            chk("t4_hold_busy", busy, 1);
            chk("t4_hold_gid", grant_id, 1);
            chk("t4_hold_ready", req_ready, 4'b0010);
            step();
        end
        hold[1] = 0;
        settle();
        chk("t4_d1", fifo_data_in, 32'h51);
        step();
        chk("t4_d2", fifo_data_in, 32'h52);
        step();
        chk("t4_bubble", busy, 0);
        step();
        chk("t4_gid3", grant_id, 3);
        chk("t4_d3", fifo_data_in, 32'h70);
        step();
        chk("t4_end_busy", busy, 0);
        chk("t4_nlog", log_d.size(), 4);
        if (log_id.size() == 4) begin
            chk("t4_log_id2", log_id[2], 1);
            chk("t4_log_id3", log_id[3], 3);
        end

        // reset mid-burst with a non-zero pointer; arbitration restarts at 0
        do_reset();
        en[0] = 1; nwords[0] = 1; last_at[0] = 0; base[0] = 8'h80;
        en[2] = 1; nwords[2] = 4; base[2] = 8'h90;
        settle();
        step();
        chk("t5_gid0", grant_id, 0);
        chk("t5_d80", fifo_data_in, 32'h80);
        step();
        chk("t5_bubble", busy, 0);
        step();
        chk("t5_gid2", grant_id, 2);
        chk("t5_d90", fifo_data_in, 32'h90);
        step();
        chk("t5_pre_wr", fifo_wr, 1);
        nrst = 1'b0;
        #1;
        chk("t5_rst_wr", fifo_wr, 0);
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_data", fifo_data_in, 0);
        step();
        chk("t5_nlog", log_d.size(), 2);
        nrst = 1'b1;
        cnt[0] = 0; base[0] = 8'h81;
        settle();
        step();
        chk("t5_restart_gid", grant_id, 0);
        chk("t5_restart_d", fifo_data_in, 32'h81);

        // full deasserts on the same cycle the last word is offered
        do_reset();
        prefill(15);
        en[1] = 1; nwords[1] = 2; last_at[1] = 1; base[1] = 8'hE0;
        settle();
        step();
        chk("t6_d0", fifo_data_in, 32'hE0);
        step();
        chk("t6_full_wr", fifo_wr, 0);
        chk("t6_full_ready", req_ready, 0);
        auto_rd = 1'b1;
        step();
        chk("t6_last_wr", fifo_wr, 1);
        chk("t6_last_d", fifo_data_in, 32'hE1);
        chk("t6_last_ready", req_ready, 4'b0010);
        step();
        chk("t6_end_busy", busy, 0);
        chk("t6_end_wr", fifo_wr, 0);
        chk("t6_nlog", log_d.size(), 2);
        cnt[1] = 0; nwords[1] = 1; last_at[1] = 0; base[1] = 8'hE8;
        en[2] = 1; nwords[2] = 1; last_at[2] = 0; base[2] = 8'hF0;
        settle();
        step();
        chk("t6_rr_gid", grant_id, 2);
        chk("t6_rr_d", fifo_data_in, 32'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one syncFifo write port between NUM_REQ producers.
- Round-robin arbitration with packet and burst locking: once granted, a requester owns the FIFO write port until it sends a word flagged last, or until MAX_BURST words have been written.
- Sits directly in front of syncFifo. Drives its wr/data_in and observes fifo_full; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 8, word width; must match the FIFO.
- MAX_BURST, 4, maximum words written per grant before forced rotation (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester last word of packet; qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_wr  out  1  to FIFO wr.
- fifo_data_in  out  DATA_WIDTH  to FIFO data_in.
- fifo_full  in  1  from FIFO fifo_full.
- grant_id  out  $clog2(NUM_REQ)  current owner; valid while busy=1.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset: one clock (clk); reset asynchronous, active-low (nrst).
- Reset state: state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0.
- Outputs during reset: busy=0, fifo_wr=0, req_ready=0, fifo_data_in=0.
- Reset mid-burst aborts the grant immediately. No word is written after nrst falls.
- State IDLE:
  - If any req_valid is high, register the winner into grant_id and go to GRANT. Nothing is written in this cycle (1-cycle arbitration latency).
  - Winner = first requester with valid high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- State GRANT, with owner o = grant_id:
  - req_ready[o] = !fifo_full (combinational). All other ready bits = 0.
  - fifo_wr = req_valid[o] && !fifo_full.
  - fifo_data_in = req_data[o]. It is 0 when fifo_wr=0.
  - Transfer occurs when req_valid[o] && req_ready[o]. On a transfer, burst_cnt increments.
  - Grant ends on a transfer with req_last[o]=1, or a transfer that makes burst_cnt == MAX_BURST.
  - At grant end: next state IDLE, rr_ptr <= (o+1) mod NUM_REQ, burst_cnt <= 0.
  - If req_valid[o] drops mid-packet, the lock holds (stall); the owner is not rotated out.
- fifo_full=1 in GRANT: ready is 0, no write, burst_cnt holds, state holds. A transfer resumes the cycle full deasserts.
- fifo_full is never overridden. The arbiter never asserts fifo_wr while full, so the FIFO's own overflow guard is redundant, not relied on.
- Requesters other than the owner may change valid freely. They are not sampled until the next IDLE.
- Requester protocol: data/last held stable while valid && !ready. Checked by bench assertion, not by RTL.
- burst_cnt width = $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- rr_ptr wraps NUM_REQ-1 -> 0.
- Single requester repeatedly valid: it regains the grant every IDLE cycle (one bubble per grant).

Decomposition:
- Package fifo_arb_pkg: typedef arb_state_e {IDLE, GRANT}, function rr_pick(req, ptr) returning the winner index and a found flag.
- One sub-module, rr_arbiter: combinational round-robin pick from request vector and pointer. Reused by future read-side scheduler.
- Top holds state register, rr_ptr, burst_cnt and output muxing.

Test Plan:
- Reset then req_valid=4'b0001, data 0xA1..0xA3, last on 3rd -> grant_id=0 one cycle later, 3 consecutive fifo_wr pulses, FIFO reads back A1,A2,A3, busy falls.
- All four valid with no last, MAX_BURST=4 -> grants in order 0,1,2,3,0. Exactly 4 writes each, one idle cycle between grants.
- Requester 2 granted, FIFO pre-filled to 15/16 -> one write, fifo_full=1, ready[2]=0 for 3 cycles with no write. Read one word, then writing resumes with burst_cnt continuing.
- Owner 1 drops valid for 2 cycles mid-packet while requester 3 is valid -> grant stays on 1, no writes from 3 until 1 sends last.
- nrst pulsed low mid-burst -> fifo_wr/req_ready/busy go 0 asynchronously. After release, arbitration restarts from rr_ptr=0.
- Simultaneous fifo_full deassert and last word -> exactly one write, grant ends, rr_ptr advances.
